// File: rtl/mux_cfg_sequencer.sv
// mux_cfg_sequencer
//   Serialises one select index per routing mux into a one-hot config
//   chain. A frame is NUM_MUX words. Each word is shifted out MSB first
//   over MUX_SIZE cycles with ccff_en high.
//
//   Optional feature: define MUX_CFG_RANGE_CHECK_EN to build the
//   out-of-range index check that drives the sticky err flag. When the
//   macro is undefined, err is tied to 0.
//
// Ports
//   prog_clk   clock, rising edge
//   pReset_n   synchronous active-low reset
//   start      one-cycle request to program a full frame
//   cfg_valid  cfg_idx is valid
//   cfg_idx    selected input index for the current mux
//   cfg_ready  word accepted this cycle when cfg_valid is also high
//   ccff_head  serial config bit into the chain
//   ccff_en    chain shift enable
//   busy       frame in progress
//   done       one-cycle end-of-frame pulse
//   err        sticky out-of-range flag
module mux_cfg_sequencer #(
  parameter int NUM_MUX  = 4,
  parameter int MUX_SIZE = 8,
  parameter int IDX_W    = 3
) (
  input  logic             prog_clk,
  input  logic             pReset_n,
  input  logic             start,
  input  logic             cfg_valid,
  input  logic [IDX_W-1:0] cfg_idx,
  output logic             cfg_ready,
  output logic             ccff_head,
  output logic             ccff_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BCW = (MUX_SIZE > 1) ? $clog2(MUX_SIZE) : 1;
  localparam int MCW = (NUM_MUX  > 1) ? $clog2(NUM_MUX)  : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t              state;
  logic [MUX_SIZE-1:0] sreg;
  logic [MUX_SIZE-1:0] sreg_nxt;
  logic [MUX_SIZE-1:0] onehot;
  logic [BCW-1:0]      bit_cnt;
  logic [MCW-1:0]      mux_cnt;

  // Indices with no matching input leave the word all-zero, which
  // disconnects the mux.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < MUX_SIZE; i++)
      if (cfg_idx == IDX_W'(i)) onehot[i] = 1'b1;
  end

  // ccff_head is registered, so it is loaded with the bit that the
  // shift register will present next cycle.
  assign sreg_nxt = sreg << 1;

  always_ff @(posedge prog_clk) begin
    if (!pReset_n) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      mux_cnt   <= '0;
      cfg_ready <= 1'b0;
      ccff_head <= 1'b0;
      ccff_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MUX_CFG_RANGE_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            mux_cnt   <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
`ifdef MUX_CFG_RANGE_CHECK_EN
            err       <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            state     <= SHIFT;
            sreg      <= onehot;
            bit_cnt   <= '0;
            cfg_ready <= 1'b0;
            ccff_en   <= 1'b1;
            ccff_head <= onehot[MUX_SIZE-1];
`ifdef MUX_CFG_RANGE_CHECK_EN
            if (~|onehot) err <= 1'b1;
`endif
          end
        end
        SHIFT: begin
          sreg <= sreg_nxt;
          if (bit_cnt == BCW'(MUX_SIZE-1)) begin
            ccff_en   <= 1'b0;
            ccff_head <= 1'b0;
            if (mux_cnt == MCW'(NUM_MUX-1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= LOAD;
              mux_cnt   <= mux_cnt + 1'b1;
              cfg_ready <= 1'b1;
            end
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            ccff_head <= sreg_nxt[MUX_SIZE-1];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MUX_CFG_RANGE_CHECK_EN
  assign err = 1'b0;
`endif

endmodule
